processor_pin_saida_blink: RTL and testbench
============================================

PROCESSOR_PIN_SAIDA_BLINK -- requirements
Module: processor_pin_saida_blink

Interface
REQ-001 SHALL have parameter PRESC_DIV, default 50000, meaning clk cycles per tick; legal range 2..65535.
REQ-002 SHALL have parameter HALF_DEFAULT, default 250, meaning reset value of half-period register in ticks.
REQ-003 SHALL have port clk, input, 1 bit, system clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port pio_in, input, 3 bits, channel request pattern from the upstream PIO out_port.
REQ-006 SHALL have port address, input, 2 bits, Avalon-MM slave word address.
REQ-007 SHALL have port chipselect, input, 1 bit, Avalon-MM select.
REQ-008 SHALL have port write_n, input, 1 bit, Avalon-MM active-low write strobe.
REQ-009 SHALL have port writedata, input, 32 bits, Avalon-MM write data.
REQ-010 SHALL have port readdata, output, 32 bits, Avalon-MM read data, zero wait states.
REQ-011 SHALL have port pin_out, output, 3 bits, registered physical pin drive.

Function
REQ-012 Write at address 0 SHALL load mode[2:0] from writedata[2:0]; bit i=0 steady, 1 blink.
REQ-013 Write at address 1 SHALL load half[15:0] from writedata[15:0]; half=0 SHALL behave as 1.
REQ-014 Writes to addresses 2 and 3 SHALL be ignored.
REQ-015 Shared prescaler SHALL count 0..PRESC_DIV-1 and assert one-cycle tick on the PRESC_DIV-1 cycle, free-running.
REQ-016 Steady channel: pin_out[i] SHALL equal pio_in[i] sampled one clk earlier (latency 1).
REQ-017 Blink channel SHALL use FSM IDLE/ON/OFF with a 16-bit down-counter cnt[i].
REQ-018 IDLE: pin_out[i]=0; pio_in[i]=1 SHALL move to ON next cycle with cnt loaded with effective half.
REQ-019 ON: pin_out[i]=1; on tick with cnt=1, SHALL move to OFF and reload cnt; otherwise decrement on tick.
REQ-020 OFF: pin_out[i]=0; on tick with cnt=1, SHALL move to ON and reload cnt; otherwise decrement on tick.
REQ-021 pio_in[i]=0 in ON or OFF SHALL force IDLE next cycle, overriding a simultaneous tick.
REQ-022 A half write mid-blink SHALL take effect at the next reload only.
REQ-023 Any write changing mode[i] SHALL force channel i to IDLE next cycle and clear cnt[i]; unchanged bits unaffected.
REQ-024 Channels SHALL be independent except for shared tick and half.

Reset
REQ-025 reset_n low SHALL asynchronously clear pin_out, mode, all FSMs (IDLE), cnt, prescaler; half SHALL load HALF_DEFAULT.
REQ-026 readdata SHALL be 0 during reset.
REQ-027 Reset mid-blink SHALL drop pin_out to 0 immediately; after release, blink restarts from IDLE.

Configuration
REQ-028 With SAIDA_BLINK_READ_EN defined, readdata SHALL return mode (address 0), half (address 1), pin_out (address 2), 0 (address 3), zero-extended, combinationally from address.
REQ-029 Without SAIDA_BLINK_READ_EN, readdata SHALL be constant 0 and no read mux SHALL be built.

Structure
REQ-030 Shared package processor_saida_pkg SHALL hold the FSM state enum (IDLE/ON/OFF), register address constants (ADDR_MODE=0, ADDR_HALF=1, ADDR_STAT=2), and HALF_W=16.
REQ-031 One sub-module processor_saida_blink_chan SHALL implement the per-channel FSM and counter, instantiated three times; prescaler and register file stay in the top.

Verification
REQ-032 Reset: assert reset_n low mid-run -> pin_out=0, readdata=0, half reads 250 after release (with macro).
REQ-033 Steady: mode=0, pio_in 3'b000->3'b101 -> pin_out=3'b101 exactly one clk later.
REQ-034 Blink: PRESC_DIV=4, half=3, mode=3'b001, pio_in[0]=1 -> pin_out[0] high 12 clk, low 12 clk, repeating; bits 1,2 follow pio_in.
REQ-035 Abort: during ON, drop pio_in[0] on a tick cycle -> pin_out[0]=0 next cycle, FSM IDLE, no toggle.
REQ-036 Half update: blinking at half=3, write half=5 mid-phase -> current phase finishes at 3 ticks, following phases 5 ticks; half=0 -> 1-tick phases.
REQ-037 Readback: with macro, write mode=3'b110, half=0x1234 -> reads 0x6, 0x1234, current pin_out, 0; without macro all reads 0.

Source files
------------

// File: rtl/processor_saida_pkg.sv
// processor_saida_pkg
//   Shared definitions for the three-channel blink output block:
//   - chan_state_e : per-channel blink FSM states (IDLE / ON / OFF)
//   - ADDR_*       : Avalon-MM word addresses of the register file
//   - HALF_W       : width of the half-period register and channel counters
//   - eff_half()   : maps a programmed half-period of 0 onto 1 tick
package processor_saida_pkg;

  localparam int HALF_W = 16;

  localparam logic [1:0] ADDR_MODE = 2'd0;
  localparam logic [1:0] ADDR_HALF = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } chan_state_e;

  // A half-period of zero would never reach the cnt==1 reload point,
  // so it is treated as the shortest legal phase of one tick.
  function automatic logic [HALF_W-1:0] eff_half(input logic [HALF_W-1:0] h);
    return (h == '0) ? {{(HALF_W-1){1'b0}}, 1'b1} : h;
  endfunction

endpackage

// File: rtl/processor_pin_saida_blink_if.sv
// processor_pin_saida_blink_if
//   Avalon-MM slave bus used to program the blink output block.
//   address    : word address (0 mode, 1 half, 2 status, 3 reserved)
//   chipselect : bus select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : read data, zero wait states
//   Modports: master (bus host / testbench), slave (the block).
interface processor_pin_saida_blink_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/processor_saida_blink_chan.sv
// processor_saida_blink_chan
//   One output channel. In steady mode the pin follows pio with one clock
//   of latency; in blink mode an IDLE/ON/OFF FSM with a down-counter of
//   ticks toggles the pin every half_eff ticks while pio stays high.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     tick         : shared one-cycle prescaler strobe
//     mode         : current mode bit (0 steady, 1 blink)
//     mode_chg     : mode bit is being rewritten to a different value this cycle
//     pio          : channel request from the upstream PIO
//     half_eff     : half-period in ticks, already mapped so it is never 0
//     pin          : registered pin drive
module processor_saida_blink_chan
  import processor_saida_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              mode,
  input  logic              mode_chg,
  input  logic              pio,
  input  logic [HALF_W-1:0] half_eff,
  output logic              pin
);

  chan_state_e       state;
  logic [HALF_W-1:0] cnt;
  logic              mode_nxt;

  // Mode value that becomes visible after this edge; used so the pin
  // reflects the new mode already on the cycle the change lands.
  assign mode_nxt = mode ^ mode_chg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      pin   <= 1'b0;
    end else if (mode_chg) begin
      state <= IDLE;
      cnt   <= '0;
      pin   <= mode_nxt ? 1'b0 : pio;
    end else if (!mode) begin
      state <= IDLE;
      cnt   <= '0;
      pin   <= pio;
    end else begin
      unique case (state)
        IDLE: begin
          if (pio) begin
            state <= ON;
            cnt   <= half_eff;
            pin   <= 1'b1;
          end else begin
            pin   <= 1'b0;
          end
        end
        ON: begin
          // Dropping the request wins over a tick arriving in the same cycle.
          if (!pio) begin
            state <= IDLE;
            cnt   <= '0;
            pin   <= 1'b0;
          end else if (tick && cnt <= {{(HALF_W-1){1'b0}}, 1'b1}) begin
            state <= OFF;
            cnt   <= half_eff;
            pin   <= 1'b0;
          end else begin
            if (tick) cnt <= cnt - 1'b1;
            pin <= 1'b1;
          end
        end
        OFF: begin
          if (!pio) begin
            state <= IDLE;
            cnt   <= '0;
            pin   <= 1'b0;
          end else if (tick && cnt <= {{(HALF_W-1){1'b0}}, 1'b1}) begin
            state <= ON;
            cnt   <= half_eff;
            pin   <= 1'b1;
          end else begin
            if (tick) cnt <= cnt - 1'b1;
            pin <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          pin   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/processor_pin_saida_blink.sv
// processor_pin_saida_blink
//   Three physical output pins driven either steadily from the upstream PIO
//   pattern or as blinking outputs, programmed over an Avalon-MM slave.
//   Parameters:
//     PRESC_DIV    : clk cycles per tick (2..65535)
//     HALF_DEFAULT : reset value of the half-period register, in ticks
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     pio_in[2:0]  : channel request pattern from the PIO out_port
//     bus          : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//     pin_out[2:0] : registered pin drive
//   Registers: 0 mode[2:0] (1 = blink), 1 half[15:0], 2/3 writes ignored.
//   Build option: define SAIDA_BLINK_READ_EN to build the read mux
//   (mode, half, pin_out, 0); otherwise readdata is constant 0.
module processor_pin_saida_blink
  import processor_saida_pkg::*;
#(
  parameter int PRESC_DIV    = 50000,
  parameter int HALF_DEFAULT = 250
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [2:0]                    pio_in,
  processor_pin_saida_blink_if.slave    bus,
  output logic [2:0]                    pin_out
);

  logic [15:0]       presc;
  logic              tick;
  logic [2:0]        mode;
  logic [HALF_W-1:0] half;
  logic [HALF_W-1:0] half_eff;
  logic              wr_en;
  logic [2:0]        mode_chg;
  logic [2:0]        chan_pin;

  // Free-running prescaler shared by all channels.
  assign tick = (presc == 16'(PRESC_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  assign wr_en = bus.chipselect && !bus.write_n;

  // Only bits whose value actually changes restart their channel.
  assign mode_chg = (wr_en && bus.address == ADDR_MODE) ?
                    (bus.writedata[2:0] ^ mode) : 3'b000;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode <= '0;
      half <= HALF_W'(HALF_DEFAULT);
    end else if (wr_en) begin
      case (bus.address)
        ADDR_MODE: mode <= bus.writedata[2:0];
        ADDR_HALF: half <= bus.writedata[HALF_W-1:0];
        default:   ;
      endcase
    end
  end

  assign half_eff = eff_half(half);

  for (genvar i = 0; i < 3; i++) begin : g_chan
    processor_saida_blink_chan u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (tick),
      .mode     (mode[i]),
      .mode_chg (mode_chg[i]),
      .pio      (pio_in[i]),
      .half_eff (half_eff),
      .pin      (chan_pin[i])
    );
  end

  assign pin_out = chan_pin;

`ifdef SAIDA_BLINK_READ_EN
  logic [31:0] rd_data;

  // Gated by reset_n so half's reset value is not visible while in reset.
  always_comb begin
    rd_data = '0;
    if (reset_n) begin
      case (bus.address)
        ADDR_MODE: rd_data = {29'b0, mode};
        ADDR_HALF: rd_data = {{(32-HALF_W){1'b0}}, half};
        ADDR_STAT: rd_data = {29'b0, pin_out};
        default:   rd_data = '0;
      endcase
    end
  end

  assign bus.readdata = rd_data;
`else
  assign bus.readdata = '0;
`endif

endmodule

// File: tb/tb_processor_pin_saida_blink.sv
module tb_processor_pin_saida_blink;
  import processor_saida_pkg::*;

`ifdef SAIDA_BLINK_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] pio_in;
  logic [2:0] pin_out;
  int         checks = 0;
  int         errors = 0;

  processor_pin_saida_blink_if bus ();

  processor_pin_saida_blink #(
    .PRESC_DIV    (4),
    .HALF_DEFAULT (250)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pio_in  (pio_in),
    .bus     (bus),
    .pin_out (pin_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic wait_lvl(input logic lvl, output bit ok);
    int k = 0;
    while (pin_out[0] !== lvl && k < 200) begin
      @(negedge clk);
      k++;
    end
    ok = (pin_out[0] === lvl);
  endtask

  // Counts consecutive negedges (from the current one) with pin_out[0]==lvl.
  task automatic measure(input logic lvl, output int n);
    n = 0;
    while (pin_out[0] === lvl && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    pio_in  = 3'b111;
    bus.address = ADDR_HALF; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (pin_out !== 3'b000) begin errors++; $display("FAIL reset_pin: got %b want 000", pin_out); end
    checks++;
    if (bus.readdata !== 32'd0) begin errors++; $display("FAIL reset_rd: got %h want 0", bus.readdata); end
    pio_in  = 3'b000;
    reset_n = 1'b1;
    @(negedge clk);
    bus.address = ADDR_HALF; #1;
    checks++;
    if (bus.readdata !== (READ_EN ? 32'd250 : 32'd0)) begin
      errors++; $display("FAIL reset_half: got %0d want %0d", bus.readdata, READ_EN ? 250 : 0);
    end
    bus.address = ADDR_MODE; #1;
    checks++;
    if (bus.readdata !== 32'd0) begin errors++; $display("FAIL reset_mode: got %h want 0", bus.readdata); end
    @(negedge clk);
  endtask

  task automatic test_steady;
    pio_in = 3'b000;
    @(negedge clk);
    checks++;
    if (pin_out !== 3'b000) begin errors++; $display("FAIL steady_zero: got %b want 000", pin_out); end
    pio_in = 3'b101;
    #1;
    checks++;
    if (pin_out !== 3'b000) begin errors++; $display("FAIL steady_latency: got %b want 000", pin_out); end
    @(negedge clk);
    checks++;
    if (pin_out !== 3'b101) begin errors++; $display("FAIL steady_follow: got %b want 101", pin_out); end
  endtask

  task automatic test_blink;
    bit ok;
    int n;
    pio_in = 3'b111;
    bus_write(ADDR_HALF, 32'd3);
    bus_write(ADDR_MODE, 32'd1);
    checks++;
    if (pin_out[2:1] !== 2'b11) begin errors++; $display("FAIL blink_side: got %b want 11", pin_out[2:1]); end
    wait_lvl(1'b1, ok);
    if (ok) wait_lvl(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL blink_start: got no toggle want toggle"); end
    measure(1'b0, n);
    checks++;
    if (n !== 12) begin errors++; $display("FAIL blink_low1: got %0d want 12", n); end
    measure(1'b1, n);
    checks++;
    if (n !== 12) begin errors++; $display("FAIL blink_high: got %0d want 12", n); end
    measure(1'b0, n);
    checks++;
    if (n !== 12) begin errors++; $display("FAIL blink_low2: got %0d want 12", n); end
    pio_in = 3'b011;
    @(negedge clk);
    checks++;
    if (pin_out !== 3'b011) begin errors++; $display("FAIL blink_mixed: got %b want 011", pin_out); end
  endtask

  task automatic test_abort;
    bit ok;
    bit stayed_low = 1'b1;
    wait_lvl(1'b0, ok);
    if (ok) wait_lvl(1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_sync: got no toggle want toggle"); end
    // First high negedge follows a tick edge; the 4th edge after it is a tick too.
    repeat (3) @(negedge clk);
    checks++;
    if (pin_out[0] !== 1'b1) begin errors++; $display("FAIL abort_on: got %b want 1", pin_out[0]); end
    pio_in[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (pin_out[0] !== 1'b0) begin errors++; $display("FAIL abort_drop: got %b want 0", pin_out[0]); end
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (pin_out[0] !== 1'b0) stayed_low = 1'b0;
    end
    checks++;
    if (!stayed_low) begin errors++; $display("FAIL abort_hold: got toggle want steady 0"); end
    pio_in[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (pin_out[0] !== 1'b1) begin errors++; $display("FAIL abort_restart: got %b want 1", pin_out[0]); end
  endtask

  task automatic test_half_update;
    bit ok;
    int n;
    wait_lvl(1'b0, ok);
    if (ok) wait_lvl(1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL half_sync: got no toggle want toggle"); end
    bus_write(ADDR_HALF, 32'd5);
    measure(1'b1, n);
    checks++;
    if (n !== 11) begin errors++; $display("FAIL half_cur: got %0d want 11", n); end
    measure(1'b0, n);
    checks++;
    if (n !== 20) begin errors++; $display("FAIL half_low5: got %0d want 20", n); end
    measure(1'b1, n);
    checks++;
    if (n !== 20) begin errors++; $display("FAIL half_high5: got %0d want 20", n); end
    bus_write(ADDR_HALF, 32'd0);
    measure(1'b0, n);
    checks++;
    if (n !== 19) begin errors++; $display("FAIL half_cur5: got %0d want 19", n); end
    measure(1'b1, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL half_high0: got %0d want 4", n); end
    measure(1'b0, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL half_low0: got %0d want 4", n); end
  endtask

  task automatic test_readback;
    logic [31:0] exp_rd [4];
    pio_in = 3'b001;
    bus_write(ADDR_MODE, 32'd6);
    bus_write(ADDR_HALF, 32'h1234);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd3, 32'hFFFF_FFFF);
    checks++;
    if (pin_out !== 3'b001) begin errors++; $display("FAIL rb_pin: got %b want 001", pin_out); end
    exp_rd[0] = READ_EN ? 32'h6    : 32'h0;
    exp_rd[1] = READ_EN ? 32'h1234 : 32'h0;
    exp_rd[2] = READ_EN ? 32'h1    : 32'h0;
    exp_rd[3] = 32'h0;
    for (int a = 0; a < 4; a++) begin
      bus.address    = 2'(a);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      #1;
      checks++;
      if (bus.readdata !== exp_rd[a]) begin
        errors++; $display("FAIL rb_addr%0d: got %h want %h", a, bus.readdata, exp_rd[a]);
      end
    end
    bus.chipselect = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_blink;
    bit ok;
    pio_in = 3'b001;
    bus_write(ADDR_HALF, 32'd2);
    bus_write(ADDR_MODE, 32'd1);
    wait_lvl(1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_blink_on: got 0 want 1"); end
    #2 reset_n = 1'b0;
    bus.address = ADDR_HALF;
    #1;
    checks++;
    if (pin_out !== 3'b000) begin errors++; $display("FAIL rst_async_pin: got %b want 000", pin_out); end
    checks++;
    if (bus.readdata !== 32'd0) begin errors++; $display("FAIL rst_async_rd: got %h want 0", bus.readdata); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (pin_out !== 3'b001) begin errors++; $display("FAIL rst_after_pin: got %b want 001", pin_out); end
    bus.address = ADDR_HALF; #1;
    checks++;
    if (bus.readdata !== (READ_EN ? 32'd250 : 32'd0)) begin
      errors++; $display("FAIL rst_after_half: got %0d want %0d", bus.readdata, READ_EN ? 250 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_blink();
    test_abort();
    test_half_update();
    test_readback();
    test_reset_mid_blink();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
